// File: rtl/packet_forwarder.sv
// Drains one packet from packet memory into an AXI-Stream master port,
// with a small skid FIFO and credit-based read issue.
module packet_forwarder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready_for_forwarder,
    input  logic [ADDR_WIDTH-1:0] len_to_forwarder,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    output logic                  forwarder_rd_en,
    input  logic [DATA_WIDTH-1:0] forwarder_rd_data,
    output logic                  forwarder_done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, DONE, GAP} state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH:0]   len_r, rd_ptr, out_cnt, len_m1;
    logic                  inflight, push, pop;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_idx, rd_idx;
    logic [CW-1:0]         count;
    logic [CW:0]           occ;

    assign len_m1 = len_r - (ADDR_WIDTH+1)'(1);
    // Occupancy includes the word still in flight from packet memory.
    assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign push  = inflight;
    assign pop   = m_axis_tvalid & m_axis_tready;

    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_idx] : '0;
    assign m_axis_tlast  = m_axis_tvalid & (out_cnt == len_m1);

    assign forwarder_rd_addr =
        forwarder_rd_en ? rd_ptr[ADDR_WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ready_for_forwarder)
                    state_nxt = (len_to_forwarder == '0) ? DONE : READ;
            end
            READ: begin
                if (forwarder_rd_en && rd_ptr == len_m1)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_cnt == len_r || (pop && m_axis_tlast))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        forwarder_rd_en = 1'b0;
        forwarder_done  = 1'b0;
        unique case (state)
            READ:    forwarder_rd_en = (occ < (CW+1)'(FIFO_DEPTH));
            DONE:    forwarder_done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r    <= '0;
            rd_ptr   <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
        end else begin
            if (state == IDLE && ready_for_forwarder) begin
                len_r   <= {1'b0, len_to_forwarder};
                rd_ptr  <= '0;
                out_cnt <= '0;
            end else begin
                if (forwarder_rd_en) rd_ptr  <= rd_ptr + (ADDR_WIDTH+1)'(1);
                if (pop)             out_cnt <= out_cnt + (ADDR_WIDTH+1)'(1);
            end
            inflight <= forwarder_rd_en;
            if (push) wr_idx <= wr_idx + PW'(1);
            if (pop)  rd_idx <= rd_idx + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= forwarder_rd_data;
    end

endmodule

// File: tb/tb_packet_forwarder.sv
// Scoreboard bench for packet_forwarder: directed packets, a packet memory
// model, and a negedge monitor that checks beats, reads and done timing.
module tb_packet_forwarder;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready = 1'b0;
    logic [AW-1:0] len = '0;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          done;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          tlast;

    always #5 clk = ~clk;

    packet_forwarder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ready_for_forwarder (ready),
        .len_to_forwarder    (len),
        .forwarder_rd_addr   (rd_addr),
        .forwarder_rd_en     (rd_en),
        .forwarder_rd_data   (rd_data),
        .forwarder_done      (done),
        .m_axis_tdata        (tdata),
        .m_axis_tvalid       (tvalid),
        .m_axis_tready       (tready),
        .m_axis_tlast        (tlast)
    );

    logic [DW-1:0] pmem [16];

    always @(posedge clk) if (rd_en) rd_data <= pmem[rd_addr[3:0]];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    beat_t b;

    int vectors = 0, errors = 0, cyc = 0;
    int issued = 0, popped = 0, exp_addr = 0, pkt_reads = 0, beats = 0;
    int done_cnt = 0, done_cyc = -1;
    int first_valid_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1;
    int tmode = 0, tcnt = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // tready: always high in mode 0, repeating 1,0,0,1 in mode 1
    always @(posedge clk) begin
        #1;
        tcnt++;
        if (tmode == 0) tready = 1'b1;
        else            tready = (tcnt % 4 == 0) || (tcnt % 4 == 3);
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid", 64'(tvalid), 64'd1);
                check("stall_tdata", tdata, prev_data);
            end
            if (rd_en) begin
                check("rd_addr", 64'(rd_addr), 64'(exp_addr));
                check("credit", 64'(issued - popped < FD), 64'd1);
                exp_addr++;
                pkt_reads++;
                issued++;
            end
            if (tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none", tdata);
                end else begin
                    b = sb.pop_front();
                    check("tdata", tdata, b.data);
                    check("tlast", 64'(tlast), 64'(b.last));
                end
                popped++;
                beats++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_tdata"}, tdata, 64'd0);
        check({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        check({tag, "_tlast"}, 64'(tlast), 64'd0);
    endtask

    // Loads memory, queues expected beats and pulses ready for one cycle.
    // Caller is aligned 1 time unit after a rising edge.
    task automatic start_pkt(input int n, input int tag, input int mode,
                             output int rcyc, output int d0);
        tmode = mode;
        for (int i = 0; i < n; i++) begin
            pmem[i] = {8'(tag), 24'h5A5A5A, 32'(i) * 32'h01010101};
            sb.push_back('{data: pmem[i], last: (i == n - 1)});
        end
        pkt_reads = 0;
        exp_addr = 0;
        beats = 0;
        first_valid_cyc = -1;
        first_hs_cyc = -1;
        last_hs_cyc = -1;
        d0 = done_cnt;
        ready = 1'b1;
        len = AW'(n);
        rcyc = cyc;
        @(posedge clk); #1;
        ready = 1'b0;
        len = '1;
    endtask

    task automatic run_pkt(input int n, input int tag, input int mode);
        int rcyc, d0;
        start_pkt(n, tag, mode, rcyc, d0);
        for (int k = 0; k < 400 && done_cnt == d0; k++) begin
            @(posedge clk); #1;
        end
        if (done_cnt == d0) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got no done expected done for len %0d", n);
        end else begin
            @(posedge clk); #1;
            check("done_pulses", 64'(done_cnt - d0), 64'd1);
            check("sb_empty", 64'(sb.size()), 64'd0);
            check("read_count", 64'(pkt_reads), 64'(n));
            if (n > 0) begin
                check("done_after_last", 64'(done_cyc - last_hs_cyc), 64'd1);
            end else begin
                check("done_len0", 64'(done_cyc - rcyc), 64'd1);
                check("no_tvalid_len0", 64'(first_valid_cyc), 64'(-1));
            end
            if (mode == 0 && n > 0) begin
                check("first_valid_lat", 64'(first_valid_cyc - rcyc), 64'd3);
                check("back_to_back", 64'(last_hs_cyc - first_hs_cyc), 64'(n - 1));
            end
        end
    endtask

    initial begin
        int rcyc, d0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_pkt(4, 8'hA0, 0);
        run_pkt(1, 8'hB1, 0);
        run_pkt(0, 8'hC2, 0);
        run_pkt(8, 8'hD3, 1);
        run_pkt(3, 8'hE4, 0);
        run_pkt(2, 8'hE5, 0);

        start_pkt(6, 8'hF6, 0, rcyc, d0);
        for (int k = 0; k < 100 && beats < 2; k++) begin
            @(posedge clk); #1;
        end
        check("abort_two_beats", 64'(beats >= 2), 64'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        sb.delete();
        issued = 0;
        popped = 0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_pkt(3, 8'h17, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
